satarx_scrambler_wide: RTL and testbench
========================================

// Module: satarx_scrambler_wide
// PURPOSE
//  Parametrised successor to the single-dword SATA Rx scrambler. Descrambles
//  NWORDS dwords per AXI-stream beat, with low-aligned partial beats via TKEEP.
//  Latches the scrambler enable once per frame and flags malformed keep masks.
//  Sits between the link-layer frame extractor and the CRC checker.
// PARAMETERS
//  NWORDS        2         dwords per beat (1..8); DW = 32*NWORDS
//  POLYNOMIAL    16'ha011  Galois LFSR feedback mask, MSB-out
//  INITIAL       16'hffff  LFSR seed at every frame start (must be nonzero)
//  OPT_LOWPOWER  1'b1      zero TDATA/TKEEP/TLAST whenever M_AXIS_TVALID is low
// PORTS
//  S_AXI_ACLK          in   1         clock
//  S_AXI_ARESET        in   1         synchronous reset, active high
//  i_cfg_scrambler_en  in   1         enable; sampled only at frame start
//  S_AXIS_TVALID       in   1         input beat valid
//  S_AXIS_TREADY       out  1         = !M_AXIS_TVALID || M_AXIS_TREADY
//  S_AXIS_TDATA        in   DW        dword i at bits [32i+31:32i]
//  S_AXIS_TKEEP        in   NWORDS    per-dword valid, contiguous from bit 0
//  S_AXIS_TLAST        in   1         last beat of frame
//  M_AXIS_TVALID       out  1         output beat valid
//  M_AXIS_TREADY       in   1         downstream ready
//  M_AXIS_TDATA        out  DW        descrambled data
//  M_AXIS_TKEEP        out  NWORDS    registered copy of S_AXIS_TKEEP
//  M_AXIS_TLAST        out  1         registered copy of S_AXIS_TLAST
//  o_keep_err          out  1         one-cycle pulse: non-contiguous TKEEP
// BEHAVIOUR
//  Reset: M_AXIS_TVALID=0, o_keep_err=0; if OPT_LOWPOWER, TDATA/TKEEP/TLAST=0.
//   Internal fill=INITIAL, state=IDLE, latched enable=0.
//  - Reset mid-frame discards the frame; no partial TLAST is produced.
//  Latency: 1 cycle; accepted beat appears on M_AXIS next cycle.
//   Output is held stable while TVALID && !TREADY.
//  LFSR: 32 Galois steps per dword; prn bit k = fill[15] before step k.
//   Kept dword i uses PRN after 32*i steps from current fill.
//   Fill advances by 32*popcount(TKEEP) steps per accepted beat.
//  FSM: IDLE -> ACTIVE on accepted beat without TLAST; ACTIVE -> IDLE on
//   accepted TLAST.
//  - Single-beat frame (TLAST on first beat) stays IDLE.
//  - On every IDLE-state acceptance, en_q <= i_cfg_scrambler_en.
//  - That beat uses the new value combinationally.
//  - en_q holds for the rest of the frame; mid-frame toggles are ignored.
//  - On accepted TLAST, and every IDLE cycle with no TVALID: fill <= INITIAL.
//  Data: kept dword -> TDATA^prn if enabled, else TDATA unchanged.
//   Unkept dword -> 0 if OPT_LOWPOWER, else passed unchanged.
//  TKEEP==0 beat: passes through and advances nothing.
//   If it carries TLAST, it still ends the frame and reseeds.
//  Non-contiguous TKEEP (e.g. 2'b10): o_keep_err pulses the cycle after
//   acceptance. Beat is still forwarded; fill advances by popcount.
//  Stall: S_AXIS held (TVALID && !TREADY) leaves fill, state and en_q
//   unchanged.
// TESTING
//  1 NWORDS=1, enable=1: 4-dword zero frame -> output matches the prior
//    single-dword scrambler dword-for-dword.
//  2 NWORDS=2, 2-beat zero frame, keep 2'b11 -> beat0 = NWORDS=1 dwords 0,1;
//    beat1 = dwords 2,3.
//  3 NWORDS=2, frame with last keep 2'b01 -> next frame word0 restarts at
//    INITIAL PRN; last beat word1 = 0.
//  4 enable=0, data 32'hDEADBEEF -> out 32'hDEADBEEF.
//    Toggling enable mid-frame changes nothing until the next frame.
//  5 M_AXIS_TREADY random 50% -> TDATA/TLAST stable while stalled;
//    payload identical to no-stall run.
//  6 TKEEP=2'b10 -> o_keep_err=1 for exactly 1 cycle; reset mid-frame ->
//    TVALID=0 next cycle; next frame scrambles from INITIAL.

Source files
------------

// File: rtl/satarx_scrambler_wide_if.sv
// satarx_scrambler_wide_if: AXI-stream beat bundle carrying NWORDS dwords with per-dword keep
//   TVALID/TREADY  beat handshake
//   TDATA          dword i at bits [32i+31:32i]
//   TKEEP          per-dword valid, low-aligned
//   TLAST          last beat of frame
interface satarx_scrambler_wide_if #(
    parameter int NWORDS = 2
) ();
    logic                   TVALID;
    logic                   TREADY;
    logic [32*NWORDS-1:0]   TDATA;
    logic [NWORDS-1:0]      TKEEP;
    logic                   TLAST;

    modport master (output TVALID, TDATA, TKEEP, TLAST, input TREADY);
    modport slave  (input TVALID, TDATA, TKEEP, TLAST, output TREADY);
endinterface

// File: rtl/satarx_scrambler_wide.sv
// satarx_scrambler_wide: SATA Rx descrambler handling NWORDS dwords per AXI-stream beat
//   S_AXI_ACLK          clock
//   S_AXI_ARESET        synchronous reset, active high
//   i_cfg_scrambler_en  scrambler enable, latched on the first beat of each frame
//   s_axis              scrambled beats from the link-layer frame extractor
//   m_axis              descrambled beats to the CRC checker, one cycle later
//   o_keep_err          one-cycle pulse after accepting a non-contiguous TKEEP
module satarx_scrambler_wide #(
    parameter int          NWORDS       = 2,
    parameter logic [15:0] POLYNOMIAL   = 16'ha011,
    parameter logic [15:0] INITIAL      = 16'hffff,
    parameter bit          OPT_LOWPOWER = 1'b1
) (
    input  logic                    S_AXI_ACLK,
    input  logic                    S_AXI_ARESET,
    input  logic                    i_cfg_scrambler_en,
    satarx_scrambler_wide_if.slave  s_axis,
    satarx_scrambler_wide_if.master m_axis,
    output logic                    o_keep_err
);
    localparam int DW = 32 * NWORDS;

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                   state_q, state_d;
    logic [15:0]              fill_q, fill_d, fill_adv;
    logic                     en_q, en_d, en_now;
    logic                     s_ready, accept, keep_gap;
    logic [NWORDS:0][15:0]    fills;
    logic [NWORDS-1:0][31:0]  prns;
    logic [DW-1:0]            dout, m_data;
    logic [NWORDS-1:0]        m_keep;
    logic                     m_valid, m_last;
    int                       cnt;

    // 32 Galois steps; bit k of the PRN dword is the MSB before step k
    function automatic logic [47:0] step32(input logic [15:0] f);
        logic [15:0] s;
        logic [31:0] p;
        s = f;
        for (int k = 0; k < 32; k++) begin
            p[k] = s[15];
            s = {s[14:0], 1'b0} ^ (s[15] ? POLYNOMIAL : 16'h0);
        end
        return {s, p};
    endfunction

    assign s_ready       = !m_valid || m_axis.TREADY;
    assign s_axis.TREADY = s_ready;
    assign accept        = s_axis.TVALID && s_ready;
    // contiguous-from-bit-0 masks are 2^n-1, so adding one clears every set bit
    assign keep_gap      = |(s_axis.TKEEP & (s_axis.TKEEP + NWORDS'(1)));
    assign en_now        = (state_q == IDLE) ? i_cfg_scrambler_en : en_q;

    // dword i always sees the PRN 32*i steps ahead; the fill only moves by the kept count
    always_comb begin
        fills[0] = fill_q;
        cnt      = 0;
        dout     = '0;
        for (int i = 0; i < NWORDS; i++) begin
            {fills[i+1], prns[i]} = step32(fills[i]);
            cnt = cnt + int'(s_axis.TKEEP[i]);
        end
        fill_adv = fills[0];
        for (int i = 1; i <= NWORDS; i++)
            if (cnt == i) fill_adv = fills[i];
        for (int i = 0; i < NWORDS; i++)
            dout[32*i +: 32] = s_axis.TKEEP[i]
                ? (en_now ? s_axis.TDATA[32*i +: 32] ^ prns[i] : s_axis.TDATA[32*i +: 32])
                : (OPT_LOWPOWER ? 32'h0 : s_axis.TDATA[32*i +: 32]);
    end

    always_comb begin
        state_d = state_q;
        en_d    = en_q;
        fill_d  = fill_q;
        if (accept) begin
            en_d    = en_now;
            state_d = s_axis.TLAST ? IDLE : ACTIVE;
            fill_d  = s_axis.TLAST ? INITIAL : fill_adv;
        end else if (state_q == IDLE && !s_axis.TVALID) begin
            fill_d  = INITIAL;
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            state_q <= IDLE;
            fill_q  <= INITIAL;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            en_q    <= en_d;
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            m_valid    <= 1'b0;
            m_data     <= '0;
            m_keep     <= '0;
            m_last     <= 1'b0;
            o_keep_err <= 1'b0;
        end else begin
            o_keep_err <= accept && keep_gap;
            if (accept) begin
                m_valid <= 1'b1;
                m_data  <= dout;
                m_keep  <= s_axis.TKEEP;
                m_last  <= s_axis.TLAST;
            end else if (s_ready) begin
                m_valid <= 1'b0;
                if (OPT_LOWPOWER) begin
                    m_data <= '0;
                    m_keep <= '0;
                    m_last <= 1'b0;
                end
            end
        end
    end

    assign m_axis.TVALID = m_valid;
    assign m_axis.TDATA  = m_data;
    assign m_axis.TKEEP  = m_keep;
    assign m_axis.TLAST  = m_last;
endmodule

// File: tb/tb_satarx_scrambler_wide.sv
// tb_satarx_scrambler_wide: self-checking bench for satarx_scrambler_wide
module tb_satarx_scrambler_wide;
    localparam int          NW   = 2;
    localparam logic [15:0] POLY = 16'ha011;
    localparam logic [15:0] SEED = 16'hffff;

    typedef struct {
        logic        en;
        logic [63:0] d;
        logic [1:0]  keep;
        logic [63:0] exp_d;
        logic        exp_ke;
    } vec_t;

    typedef struct {
        logic [63:0] d;
        logic [1:0]  keep;
        logic        last;
    } beat_t;

    logic        clk    = 1'b0;
    logic        rst    = 1'b1;
    logic        cfg_en = 1'b0;
    logic        keep_err, keep_err1;
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] prn_tab [64];
    vec_t        tab [8];
    beat_t       q [$];
    logic        done  = 1'b0;
    logic        drain = 1'b0;

    always #5 clk = ~clk;

    satarx_scrambler_wide_if #(.NWORDS(NW)) s_if ();
    satarx_scrambler_wide_if #(.NWORDS(NW)) m_if ();
    satarx_scrambler_wide_if #(.NWORDS(1))  s1_if ();
    satarx_scrambler_wide_if #(.NWORDS(1))  m1_if ();

    satarx_scrambler_wide #(.NWORDS(NW)) dut (
        .S_AXI_ACLK         (clk),
        .S_AXI_ARESET       (rst),
        .i_cfg_scrambler_en (cfg_en),
        .s_axis             (s_if),
        .m_axis             (m_if),
        .o_keep_err         (keep_err)
    );

    satarx_scrambler_wide #(.NWORDS(1)) dut1 (
        .S_AXI_ACLK         (clk),
        .S_AXI_ARESET       (rst),
        .i_cfg_scrambler_en (1'b1),
        .s_axis             (s1_if),
        .m_axis             (m1_if),
        .o_keep_err         (keep_err1)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // scrambler bitstream from the seed, cut into consecutive dwords (first bit -> bit 0)
    task automatic build_prn();
        logic [15:0] f;
        f = SEED;
        for (int n = 0; n < 64; n++)
            for (int b = 0; b < 32; b++) begin
                prn_tab[n][b] = f[15];
                f = {f[14:0], 1'b0} ^ (f[15] ? POLY : 16'h0);
            end
    endtask

    task automatic step(input logic v, input logic [63:0] d, input logic [1:0] k, input logic l);
        @(posedge clk); #1;
        s_if.TVALID = v;
        s_if.TDATA  = d;
        s_if.TKEEP  = k;
        s_if.TLAST  = l;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [63:0] d,
                           input logic [1:0] k, input logic l, input logic ke);
        @(negedge clk);
        check({tag, " tvalid"}, m_if.TVALID, v);
        check({tag, " tdata"}, m_if.TDATA, d);
        check({tag, " tkeep"}, m_if.TKEEP, k);
        check({tag, " tlast"}, m_if.TLAST, l);
        check({tag, " keep_err"}, keep_err, ke);
    endtask

    task automatic send(input logic [63:0] d, input logic [1:0] k, input logic l);
        int w = 0;
        s_if.TVALID = 1'b1;
        s_if.TDATA  = d;
        s_if.TKEEP  = k;
        s_if.TLAST  = l;
        @(negedge clk);
        while (!s_if.TREADY && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("send tready", s_if.TREADY, 1'b1);
        @(posedge clk); #1;
        s_if.TVALID = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] p01;
        int          word;
        logic        in_frame, mdl_en, ke_pend;

        s_if.TVALID = 0; s_if.TDATA = 0; s_if.TKEEP = 0; s_if.TLAST = 0;
        s1_if.TVALID = 0; s1_if.TDATA = 0; s1_if.TKEEP = 0; s1_if.TLAST = 0;
        m_if.TREADY = 1; m1_if.TREADY = 1;
        build_prn();
        p01 = {prn_tab[1], prn_tab[0]};
        tab[0] = '{1'b1, 64'h0, 2'b11, p01, 1'b0};
        tab[1] = '{1'b0, 64'hDEADBEEF_DEADBEEF, 2'b11, 64'hDEADBEEF_DEADBEEF, 1'b0};
        tab[2] = '{1'b1, 64'h0, 2'b01, {32'h0, prn_tab[0]}, 1'b0};
        tab[3] = '{1'b1, 64'h0, 2'b10, {prn_tab[1], 32'h0}, 1'b1};
        tab[4] = '{1'b1, 64'h0, 2'b00, 64'h0, 1'b0};
        tab[5] = '{1'b0, 64'h12345678_DEADBEEF, 2'b01, 64'h00000000_DEADBEEF, 1'b0};
        tab[6] = '{1'b1, 64'hA5A5A5A5_5A5A5A5A, 2'b11, 64'hA5A5A5A5_5A5A5A5A ^ p01, 1'b0};
        tab[7] = '{1'b0, 64'hCAFEF00D_0BADC0DE, 2'b10, 64'hCAFEF00D_00000000, 1'b1};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk_out("reset", 1'b0, 64'h0, 2'b00, 1'b0, 1'b0);
        check("reset s_tready", s_if.TREADY, 1'b1);
        check("reset n1 tvalid", m1_if.TVALID, 1'b0);

        // NWORDS=1: four zero dwords read back as the raw scrambler sequence
        for (int i = 0; i <= 4; i++) begin
            @(posedge clk); #1;
            s1_if.TVALID = (i < 4);
            s1_if.TKEEP  = 1'b1;
            s1_if.TLAST  = (i == 3);
            if (i > 0) begin
                @(negedge clk);
                check("n1 tvalid", m1_if.TVALID, 1'b1);
                check("n1 tdata", m1_if.TDATA, prn_tab[i-1]);
                check("n1 tlast", m1_if.TLAST, i == 4);
                check("n1 keep_err", keep_err1, 1'b0);
            end
        end

        // single-beat frames: every one starts from the seed
        for (int i = 0; i < 8; i++) begin
            cfg_en = tab[i].en;
            step(1'b1, tab[i].d, tab[i].keep, 1'b1);
            step(1'b0, 64'h0, 2'b00, 1'b0);
            chk_out($sformatf("vec%0d", i), 1'b1, tab[i].exp_d, tab[i].keep, 1'b1, tab[i].exp_ke);
            step(1'b0, 64'h0, 2'b00, 1'b0);
            chk_out($sformatf("vec%0d idle", i), 1'b0, 64'h0, 2'b00, 1'b0, 1'b0);
        end

        // partial last beat, then the next frame restarts from the seed
        cfg_en = 1'b1;
        step(1'b1, 64'h0, 2'b11, 1'b0);
        step(1'b1, 64'h0, 2'b01, 1'b1);
        chk_out("part b0", 1'b1, p01, 2'b11, 1'b0, 1'b0);
        step(1'b1, 64'h0, 2'b11, 1'b1);
        chk_out("part b1", 1'b1, {32'h0, prn_tab[2]}, 2'b01, 1'b1, 1'b0);
        step(1'b0, 64'h0, 2'b00, 1'b0);
        chk_out("part next", 1'b1, p01, 2'b11, 1'b1, 1'b0);

        // enable latched per frame: mid-frame toggles are ignored
        cfg_en = 1'b0;
        step(1'b1, 64'hDEADBEEF_DEADBEEF, 2'b11, 1'b0);
        step(1'b1, 64'h01234567_89ABCDEF, 2'b11, 1'b0);
        cfg_en = 1'b1;
        chk_out("en0 b0", 1'b1, 64'hDEADBEEF_DEADBEEF, 2'b11, 1'b0, 1'b0);
        step(1'b1, 64'h0, 2'b11, 1'b1);
        chk_out("en0 b1", 1'b1, 64'h01234567_89ABCDEF, 2'b11, 1'b0, 1'b0);
        step(1'b1, 64'h0, 2'b11, 1'b1);
        chk_out("en0 b2", 1'b1, 64'h0, 2'b11, 1'b1, 1'b0);
        step(1'b1, 64'h0, 2'b11, 1'b0);
        chk_out("en1 single", 1'b1, p01, 2'b11, 1'b1, 1'b0);
        step(1'b1, 64'h0, 2'b11, 1'b1);
        cfg_en = 1'b0;
        chk_out("en1 b0", 1'b1, p01, 2'b11, 1'b0, 1'b0);
        step(1'b0, 64'h0, 2'b00, 1'b0);
        chk_out("en1 b1", 1'b1, {prn_tab[3], prn_tab[2]}, 2'b11, 1'b1, 1'b0);

        // reset mid-frame drops the frame; the next one scrambles from the seed
        cfg_en = 1'b1;
        step(1'b1, 64'h0, 2'b11, 1'b0);
        step(1'b1, 64'h0, 2'b11, 1'b0);
        chk_out("rst b0", 1'b1, p01, 2'b11, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        s_if.TVALID = 1'b0;
        chk_out("rst b1", 1'b1, {prn_tab[3], prn_tab[2]}, 2'b11, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk_out("rst after", 1'b0, 64'h0, 2'b00, 1'b0, 1'b0);
        step(1'b1, 64'h0, 2'b11, 1'b1);
        step(1'b0, 64'h0, 2'b00, 1'b0);
        chk_out("rst next", 1'b1, p01, 2'b11, 1'b1, 1'b0);
        step(1'b0, 64'h0, 2'b00, 1'b0);

        // random frames with random backpressure against a frame-level model
        word = 0; in_frame = 1'b0; mdl_en = 1'b0; ke_pend = 1'b0;
        fork
            begin
                int nb;
                for (int f = 0; f < 40; f++) begin
                    nb = $urandom_range(1, 6);
                    cfg_en = 1'($urandom_range(0, 1));
                    for (int b = 0; b < nb; b++) begin
                        repeat ($urandom_range(0, 2)) begin
                            @(posedge clk); #1;
                        end
                        if (b > 0 && $urandom_range(0, 3) == 0) cfg_en = ~cfg_en;
                        send({$urandom, $urandom}, 2'($urandom_range(0, 3)), b == nb - 1);
                    end
                end
                drain = 1'b1;
                repeat (6) @(posedge clk);
                #1 done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    m_if.TREADY = drain ? 1'b1 : 1'($urandom_range(0, 1));
                end
            end
            begin
                beat_t bt;
                while (!done) begin
                    @(negedge clk);
                    check("rnd tvalid", m_if.TVALID, q.size() != 0);
                    if (m_if.TVALID && q.size() != 0) begin
                        check("rnd tdata", m_if.TDATA, q[0].d);
                        check("rnd tkeep", m_if.TKEEP, q[0].keep);
                        check("rnd tlast", m_if.TLAST, q[0].last);
                        if (m_if.TREADY) void'(q.pop_front());
                    end else if (!m_if.TVALID) begin
                        check("rnd idle tdata", m_if.TDATA, 64'h0);
                        check("rnd idle tkeep/tlast", {m_if.TKEEP, m_if.TLAST}, 3'b000);
                    end
                    check("rnd keep_err", keep_err, ke_pend);
                    ke_pend = 1'b0;
                    if (s_if.TVALID && s_if.TREADY) begin
                        if (!in_frame) mdl_en = cfg_en;
                        bt.d = '0;
                        for (int i = 0; i < NW; i++)
                            if (s_if.TKEEP[i])
                                bt.d[32*i +: 32] = s_if.TDATA[32*i +: 32] ^ (mdl_en ? prn_tab[word + i] : 32'h0);
                        bt.keep = s_if.TKEEP;
                        bt.last = s_if.TLAST;
                        q.push_back(bt);
                        ke_pend  = int'(s_if.TKEEP) != (1 << $countones(s_if.TKEEP)) - 1;
                        word     = s_if.TLAST ? 0 : word + $countones(s_if.TKEEP);
                        in_frame = !s_if.TLAST;
                    end
                end
            end
        join
        check("rnd drained", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
